palette_layer_arbiter: RTL and testbench
========================================

Name: palette_layer_arbiter

Overview:
Per-pixel arbiter sharing the single 16-entry sprite palette lookup (4-bit index in, 4/4/4 RGB out) between NUM_LAYERS sprite/background layers. Each pixel clock it picks the highest-priority opaque layer, drives the palette index, then scales the returned colour by a frame-stepped fade level. It sits between the sprite ROM address logic and the VGA output registers, and also sequences game-over fade-in/out.

Parameters:
NUM_LAYERS, 3, number of index layers; layer 0 has highest priority
FRAMES_PER_STEP, 2, vsync pulses per fade-level step (>=1)

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
vsync_pulse  in  1  one-cycle strobe at frame start
blank  in  1  1 = active video, 0 = blanking
layer_idx  in  4*NUM_LAYERS  palette index per layer; layer k at bits [4k+3:4k]
layer_en  in  NUM_LAYERS  per-layer enable
fade_start  in  1  one-cycle command to start a fade
fade_dir  in  1  1 = fade in (toward 15), 0 = fade out (toward 0); sampled with fade_start
pal_index  out  4  index to shared palette (registered)
pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_index
red, green, blue  out  4 each  final pixel colour (registered)
grant  out  NUM_LAYERS  one-hot winning layer, aligned with pal_index; all-zero if none
fade_level  out  4  current brightness 0..15
fade_busy  out  1  1 while ramping

Behaviour:
- Reset (async, Reset_n=0): pal_index=0, grant=0, red/green/blue=0, fade_level=0, fade_busy=0, FSM=IDLE, frame counter=0, pipeline blank flags=0.
- Index 0 = transparent. Layer k is a candidate iff layer_en[k]=1 and its index != 0.
- Stage 1 (edge n): winner = lowest-numbered candidate; pal_index <= winner's index, grant <= one-hot(winner); no candidate -> pal_index <= 0, grant <= 0. blank registered as blank_d1.
- Stage 2 (edge n+1): channel c <= (pal_c * (fade_level + 1)) >> 4 (8-bit intermediate, take bits [7:4]); forced to 0 when blank_d1=0. Uses fade_level as of edge n+1. Total latency input -> RGB = 2 clocks.
- Level 15 -> exact palette colour; level 0 -> all channels 0 for all palette values.
- Fade FSM, states IDLE, RAMP:
  - IDLE: fade_start=1 -> latch dir, counter=0; if fade_level already equals target (15 for in, 0 for out) stay IDLE, else RAMP.
  - RAMP: on vsync_pulse, counter++; when counter reaches FRAMES_PER_STEP-1, counter=0 and fade_level +/-1; if new level equals target -> IDLE.
  - fade_start in RAMP: re-latch dir, counter=0, continue from current level (IDLE immediately if already at new target).
  - fade_start and vsync_pulse in same cycle: start wins, pulse not counted.
  - fade_busy = (state == RAMP), registered with state.
- fade_level never wraps; saturates at 0/15 by construction.
- Reset_n asserted mid-ramp or mid-pixel: all state clears immediately; first valid RGB 2 clocks after release.

Decomposition:
- Shared package: typedef of the fade FSM state enum {IDLE, RAMP}; constants TRANSPARENT_IDX=4'h0, LEVEL_MAX=4'hF, COLOR_W=4.
- One natural sub-module: fade_sequencer (FSM + frame counter, outputs fade_level/fade_busy); arbitration and scaling pipeline stay in the top.

Test Plan:
- Priority: layer_en=3'b111, idx={L2=5, L1=0, L0=0}, level 15 -> pal_index=5, grant=3'b100 after 1 clk; RGB = palette[5] after 2 clks.
- Override: idx={L2=5, L1=9, L0=2} all enabled -> pal_index=2, grant=3'b001; disable L0 -> pal_index=9, grant=3'b010.
- Transparent/blank: all idx=0 -> pal_index=0, grant=0; blank=0 with opaque layer -> RGB=0 exactly 2 clks after blank falls.
- Fade-in: reset, fade_start dir=1, FRAMES_PER_STEP=2 -> level increments every 2nd vsync_pulse, reaches 15 after 30 pulses, fade_busy drops same edge; palette red=0xA at level 7 -> red=0x5.
- Reverse mid-ramp: at level 6 issue fade_start dir=0 together with vsync_pulse -> pulse ignored, counter=0, level 5 after next 2 pulses; fade_start dir=0 at level 0 -> stays IDLE, busy never asserts.
- Async reset mid-ramp at level 9: Reset_n low without clock edge -> fade_level=0, RGB=0, grant=0 immediately.

Source files
------------

// File: rtl/palette_layer_arbiter_pkg.sv
// Shared types and constants for the palette layer arbiter and its fade sequencer.
package palette_layer_arbiter_pkg;

    localparam int unsigned COLOR_W         = 4;
    localparam logic [3:0]  TRANSPARENT_IDX = 4'h0;
    localparam logic [3:0]  LEVEL_MAX       = 4'hF;

    typedef enum logic {
        StIdle,
        StRamp
    } fade_state_e;

    // Brightness scaling: (c * (level + 1)) >> 4, so level 15 is identity and level 0 is black.
    function automatic logic [COLOR_W-1:0] scale_channel(input logic [COLOR_W-1:0] c,
                                                         input logic [3:0]         level);
        logic [7:0] prod;
        prod = {4'b0000, c} * ({4'b0000, level} + 8'd1);
        return prod[7:4];
    endfunction

endpackage

// File: rtl/palette_layer_arbiter_fade_sequencer.sv
// Frame-stepped fade sequencer: ramps fade_level toward 15 (in) or 0 (out),
// one level every FRAMES_PER_STEP vsync pulses.
module palette_layer_arbiter_fade_sequencer
    import palette_layer_arbiter_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vsync_pulse_i,
    input  logic       fade_start_i,
    input  logic       fade_dir_i,
    output logic [3:0] fade_level_o,
    output logic       fade_busy_o
);

    localparam int unsigned      CntW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);

    fade_state_e     state_q, state_d;
    logic            dir_q, dir_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      level_q, level_d;
    logic [3:0]      target_q;

    assign target_q = dir_q ? LEVEL_MAX : 4'h0;

    // Next-state: a start command always wins over a coincident vsync pulse.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (fade_start_i) begin
            dir_d   = fade_dir_i;
            cnt_d   = '0;
            state_d = (level_q == (fade_dir_i ? LEVEL_MAX : 4'h0)) ? StIdle : StRamp;
        end else if (state_q == StRamp && vsync_pulse_i) begin
            if (cnt_q == CntLast) begin
                cnt_d   = '0;
                level_d = dir_q ? level_q + 4'd1 : level_q - 4'd1;
                if (level_d == target_q) begin
                    state_d = StIdle;
                end
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            level_q <= 4'h0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign fade_level_o = level_q;
    assign fade_busy_o  = (state_q == StRamp);

endmodule

// File: rtl/palette_layer_arbiter.sv
// Per-pixel layer arbiter for the shared sprite palette: stage 1 picks the
// highest-priority opaque layer and drives the palette index, stage 2 scales
// the returned colour by the current fade level.
module palette_layer_arbiter
    import palette_layer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_LAYERS      = 3,
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    vsync_pulse,
    input  logic                    blank,
    input  logic [4*NUM_LAYERS-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]   layer_en,
    input  logic                    fade_start,
    input  logic                    fade_dir,
    output logic [3:0]              pal_index,
    input  logic [COLOR_W-1:0]      pal_red,
    input  logic [COLOR_W-1:0]      pal_green,
    input  logic [COLOR_W-1:0]      pal_blue,
    output logic [COLOR_W-1:0]      red,
    output logic [COLOR_W-1:0]      green,
    output logic [COLOR_W-1:0]      blue,
    output logic [NUM_LAYERS-1:0]   grant,
    output logic [3:0]              fade_level,
    output logic                    fade_busy
);

    logic [3:0]            win_idx;
    logic [NUM_LAYERS-1:0] win_grant;
    logic                  found;
    logic                  blank_d1;

    // Priority select: lowest-numbered enabled layer with a non-transparent index.
    always_comb begin
        win_idx   = TRANSPARENT_IDX;
        win_grant = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (!found && layer_en[k] && layer_idx[4*k +: 4] != TRANSPARENT_IDX) begin
                found        = 1'b1;
                win_idx      = layer_idx[4*k +: 4];
                win_grant[k] = 1'b1;
            end
        end
    end

    // Stage 1: register palette index, grant and the blank flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pal_index <= TRANSPARENT_IDX;
            grant     <= '0;
            blank_d1  <= 1'b0;
        end else begin
            pal_index <= win_idx;
            grant     <= win_grant;
            blank_d1  <= blank;
        end
    end

    // Stage 2: fade-scale the palette colour, black during blanking.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (!blank_d1) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            red   <= scale_channel(pal_red, fade_level);
            green <= scale_channel(pal_green, fade_level);
            blue  <= scale_channel(pal_blue, fade_level);
        end
    end

    palette_layer_arbiter_fade_sequencer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_fade_sequencer (
        .clk_i        (Clk),
        .rst_ni       (Reset_n),
        .vsync_pulse_i(vsync_pulse),
        .fade_start_i (fade_start),
        .fade_dir_i   (fade_dir),
        .fade_level_o (fade_level),
        .fade_busy_o  (fade_busy)
    );

endmodule

// File: tb/tb_palette_layer_arbiter.sv
// Self-checking bench: behavioural pixel/fade model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_palette_layer_arbiter;

    localparam int unsigned NL  = 3;
    localparam int unsigned FPS = 2;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          vsync_pulse = 1'b0;
    logic          blank = 1'b0;
    logic [4*NL-1:0] layer_idx = '0;
    logic [NL-1:0] layer_en = '0;
    logic          fade_start = 1'b0;
    logic          fade_dir = 1'b0;
    logic [3:0]    pal_index, pal_red, pal_green, pal_blue;
    logic [3:0]    red, green, blue, fade_level;
    logic [NL-1:0] grant;
    logic          fade_busy;

    int tests = 0;
    int fails = 0;

    // Model state
    int m_idx, m_grant, m_r, m_g, m_b, m_bd1, m_level, m_busy, m_dir, m_pulses;

    // Palette contents (the shared ROM the DUT looks up)
    function automatic logic [3:0] pr(input logic [3:0] i);
        return i;
    endfunction
    function automatic logic [3:0] pg(input logic [3:0] i);
        return 4'hF - i;
    endfunction
    function automatic logic [3:0] pb(input logic [3:0] i);
        return 4'((int'(i) * 7) % 16);
    endfunction

    assign pal_red   = pr(pal_index);
    assign pal_green = pg(pal_index);
    assign pal_blue  = pb(pal_index);

    palette_layer_arbiter #(
        .NUM_LAYERS     (NL),
        .FRAMES_PER_STEP(FPS)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .vsync_pulse(vsync_pulse),
        .blank      (blank),
        .layer_idx  (layer_idx),
        .layer_en   (layer_en),
        .fade_start (fade_start),
        .fade_dir   (fade_dir),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .grant      (grant),
        .fade_level (fade_level),
        .fade_busy  (fade_busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scale(input int c, input int lvl);
        return (c * (lvl + 1)) / 16;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_grant = 0; m_r = 0; m_g = 0; m_b = 0; m_bd1 = 0;
        m_level = 0; m_busy = 0; m_dir = 0; m_pulses = 0;
    endtask

    // Advance the model by one pixel clock using the inputs currently driven.
    task automatic model_step();
        int nidx, ngrant, tgt;
        if (m_bd1 != 0) begin
            m_r = scale(int'(pr(4'(m_idx))), m_level);
            m_g = scale(int'(pg(4'(m_idx))), m_level);
            m_b = scale(int'(pb(4'(m_idx))), m_level);
        end else begin
            m_r = 0; m_g = 0; m_b = 0;
        end
        nidx = 0;
        ngrant = 0;
        for (int k = 0; k < NL; k++) begin
            if (layer_en[k] && layer_idx[4*k +: 4] != 4'h0) begin
                nidx = int'(layer_idx[4*k +: 4]);
                ngrant = 1 << k;
                break;
            end
        end
        m_idx = nidx;
        m_grant = ngrant;
        m_bd1 = int'(blank);
        if (fade_start) begin
            m_dir = int'(fade_dir);
            m_pulses = 0;
            tgt = fade_dir ? 15 : 0;
            m_busy = (m_level != tgt) ? 1 : 0;
        end else if (m_busy != 0 && vsync_pulse) begin
            m_pulses++;
            if (m_pulses == FPS) begin
                m_pulses = 0;
                m_level = m_level + ((m_dir != 0) ? 1 : -1);
                tgt = (m_dir != 0) ? 15 : 0;
                if (m_level == tgt) m_busy = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("pal_index", int'(pal_index), m_idx);
        check("grant", int'(grant), m_grant);
        check("red", int'(red), m_r);
        check("green", int'(green), m_g);
        check("blue", int'(blue), m_b);
        check("fade_level", int'(fade_level), m_level);
        check("fade_busy", int'(fade_busy), m_busy);
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        vsync_pulse = 1'b0; blank = 1'b0; layer_idx = '0; layer_en = '0;
        fade_start = 1'b0; fade_dir = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        compare_all();
        Reset_n = 1'b1;
    endtask

    task automatic set_px(input int i2, input int i1, input int i0, input int en, input int bl);
        layer_idx = {4'(i2), 4'(i1), 4'(i0)};
        layer_en = 3'(en);
        blank = bl[0];
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            vsync_pulse = 1'b1;
            cycle();
            vsync_pulse = 1'b0;
            cycle();
        end
    endtask

    task automatic start_fade(input int dir, input int with_vsync);
        fade_start = 1'b1;
        fade_dir = dir[0];
        vsync_pulse = with_vsync[0];
        cycle();
        fade_start = 1'b0;
        vsync_pulse = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state
        do_reset();
        check("reset_level", int'(fade_level), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_red", int'(red), 0);
        check("reset_busy", int'(fade_busy), 0);

        // Fade in, with a level-7 colour check along the way
        start_fade(1, 0);
        check("fadein_busy", int'(fade_busy), 1);
        pulses(14);
        check("fadein_level7", int'(fade_level), 7);
        set_px(0, 0, 10, 3'b001, 1);
        cycle();
        cycle();
        check("level7_red", int'(red), 5);
        check("level7_index", int'(pal_index), 10);
        pulses(14);
        vsync_pulse = 1'b1;
        cycle();
        vsync_pulse = 1'b0;
        check("fadein_level14", int'(fade_level), 14);
        check("fadein_busy29", int'(fade_busy), 1);
        vsync_pulse = 1'b1;
        cycle();
        vsync_pulse = 1'b0;
        check("fadein_level15", int'(fade_level), 15);
        check("fadein_done", int'(fade_busy), 0);

        // Priority and override at full brightness
        set_px(5, 0, 0, 3'b111, 1);
        cycle();
        check("prio_index", int'(pal_index), 5);
        check("prio_grant", int'(grant), 4);
        cycle();
        check("prio_red", int'(red), 5);
        check("prio_green", int'(green), 10);
        check("prio_blue", int'(blue), 3);
        set_px(5, 9, 2, 3'b111, 1);
        cycle();
        check("ovr_index", int'(pal_index), 2);
        check("ovr_grant", int'(grant), 1);
        set_px(5, 9, 2, 3'b110, 1);
        cycle();
        check("dis0_index", int'(pal_index), 9);
        check("dis0_grant", int'(grant), 2);
        set_px(0, 0, 0, 3'b111, 1);
        cycle();
        check("transp_index", int'(pal_index), 0);
        check("transp_grant", int'(grant), 0);

        // Blanking: colour goes black exactly two clocks after blank falls
        set_px(0, 0, 7, 3'b111, 1);
        cycle();
        cycle();
        check("pre_blank_red", int'(red), 7);
        blank = 1'b0;
        cycle();
        check("blank_1clk_red", int'(red), 7);
        cycle();
        check("blank_2clk_red", int'(red), 0);
        check("blank_2clk_green", int'(green), 0);

        // Reverse mid-ramp with coincident vsync
        do_reset();
        start_fade(1, 0);
        pulses(12);
        check("rev_level6", int'(fade_level), 6);
        start_fade(0, 1);
        check("rev_level_hold", int'(fade_level), 6);
        check("rev_busy", int'(fade_busy), 1);
        pulses(1);
        check("rev_after1", int'(fade_level), 6);
        vsync_pulse = 1'b1;
        cycle();
        vsync_pulse = 1'b0;
        check("rev_after2", int'(fade_level), 5);
        cycle();
        pulses(10);
        check("rev_level0", int'(fade_level), 0);
        check("rev_idle", int'(fade_busy), 0);
        start_fade(0, 0);
        check("out_at0_busy", int'(fade_busy), 0);
        cycle();
        check("out_at0_busy2", int'(fade_busy), 0);

        // Asynchronous reset mid-ramp at level 9
        do_reset();
        set_px(0, 0, 10, 3'b001, 1);
        start_fade(1, 0);
        pulses(18);
        check("async_pre_level", int'(fade_level), 9);
        check("async_pre_red", int'(red), 6);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_level", int'(fade_level), 0);
        check("async_red", int'(red), 0);
        check("async_grant", int'(grant), 0);
        check("async_index", int'(pal_index), 0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        cycle();
        cycle();
        start_fade(1, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic [11:0] raw, mask;
            raw = 12'($urandom);
            mask = 12'($urandom) | 12'($urandom);
            layer_idx = raw & mask;
            layer_en = 3'($urandom);
            blank = ($urandom % 8) != 0;
            vsync_pulse = ($urandom % 3) == 0;
            fade_start = ($urandom % 80) == 0;
            fade_dir = 1'($urandom);
            cycle();
        end
        fade_start = 1'b0;
        vsync_pulse = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
